// File: rtl/alu_issue_stage.sv
// Operand-fetch / writeback stage in front of a combinational ALU.
// Holds the register file, issues one instruction per two cycles and writes r1 back.
module alu_issue_stage #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [2:0]    instr_op,
   input  logic [AW-1:0] instr_rd,
   input  logic [AW-1:0] instr_rs2,
   input  logic [AW-1:0] instr_rs3,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data,
   output logic [DW-1:0] r2,
   output logic [DW-1:0] r3,
   output logic [2:0]    aop,
   input  logic [DW-1:0] r1,
   output logic [DW-1:0] result,
   output logic          done
);

   localparam int unsigned NREG = 1 << AW;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t        state;
   logic [DW-1:0] rf [NREG];
   logic [AW-1:0] rd_q;
   logic [DW-1:0] op2_c;
   logic [DW-1:0] op3_c;
   logic          accept_c;

   assign accept_c = instr_valid && instr_ready;
   assign dbg_data = rf[dbg_addr];

   // Operand read with same-cycle preload bypass; R0 is never bypassed.
   always_comb begin
      op2_c = rf[instr_rs2];
      op3_c = rf[instr_rs3];
      if (ld_en && (ld_addr == instr_rs2) && (instr_rs2 != '0)) op2_c = ld_data;
      if (ld_en && (ld_addr == instr_rs3) && (instr_rs3 != '0)) op3_c = ld_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         instr_ready <= 1'b1;
         r2          <= '0;
         r3          <= '0;
         aop         <= '0;
         result      <= '0;
         done        <= 1'b0;
         rd_q        <= '0;
         for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         done <= 1'b0;
         // Preload first so a same-cycle writeback to the same register overrides it.
         if (ld_en && (ld_addr != '0)) rf[ld_addr] <= ld_data;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  r2          <= op2_c;
                  r3          <= op3_c;
                  aop         <= instr_op;
                  rd_q        <= instr_rd;
                  instr_ready <= 1'b0;
                  state       <= EXEC;
               end
            end
            EXEC: begin
               if (rd_q != '0) rf[rd_q] <= r1;
               result      <= r1;
               done        <= 1'b1;
               instr_ready <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               instr_ready <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: ALU stub r1 = r2 + r3, register-file model as a plain array,
// directed plan followed by randomized issue/preload traffic.
module tb_alu_issue_stage;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          instr_valid = 1'b0;
   logic          instr_ready;
   logic [2:0]    instr_op = '0;
   logic [AW-1:0] instr_rd = '0;
   logic [AW-1:0] instr_rs2 = '0;
   logic [AW-1:0] instr_rs3 = '0;
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;
   logic [AW-1:0] dbg_addr = '0;
   logic [DW-1:0] dbg_data;
   logic [DW-1:0] r2;
   logic [DW-1:0] r3;
   logic [2:0]    aop;
   logic [DW-1:0] r1;
   logic [DW-1:0] result;
   logic          done;

   int n_chk  = 0;
   int n_fail = 0;
   logic [DW-1:0] mrf [8];

   always #5 clk = ~clk;

   assign r1 = r2 + r3;

   alu_issue_stage #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
      .instr_rd(instr_rd), .instr_rs2(instr_rs2), .instr_rs3(instr_rs3),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .r2(r2), .r3(r3), .aop(aop), .r1(r1),
      .result(result), .done(done)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mrf[i] = '0;
   endtask

   task automatic chk_rf(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = AW'(i);
         #1;
         chk($sformatf("%s_dbg%0d", tag, i), dbg_data, mrf[i]);
      end
   endtask

   task automatic preload(input int a, input logic [DW-1:0] d);
      ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
      tick();
      ld_en = 1'b0;
      if (a != 0) mrf[a] = d;
   endtask

   // Issue one instruction; optional preloads in the accept cycle (la_*) and in EXEC (le_*),
   // optional ignored valid pulse during EXEC. Returns in the cycle where done is high.
   task automatic issue(input string tag, input int op, input int rd, input int rs2, input int rs3,
                        input bit la_en, input int la_a, input logic [DW-1:0] la_d,
                        input bit le_en, input int le_a, input logic [DW-1:0] le_d,
                        input bit noise);
      logic [DW-1:0] a, b, sum;
      chk({tag, "_ready_idle"}, DW'(instr_ready), DW'(1));
      a = (la_en && la_a == rs2 && rs2 != 0) ? la_d : mrf[rs2];
      b = (la_en && la_a == rs3 && rs3 != 0) ? la_d : mrf[rs3];
      instr_valid = 1'b1; instr_op = 3'(op); instr_rd = AW'(rd);
      instr_rs2 = AW'(rs2); instr_rs3 = AW'(rs3);
      ld_en = la_en; ld_addr = AW'(la_a); ld_data = la_d;
      tick();
      if (la_en && la_a != 0) mrf[la_a] = la_d;
      instr_valid = 1'b0; ld_en = 1'b0;
      chk({tag, "_r2"}, r2, a);
      chk({tag, "_r3"}, r3, b);
      chk({tag, "_aop"}, DW'(aop), DW'(op));
      chk({tag, "_ready_exec"}, DW'(instr_ready), DW'(0));
      chk({tag, "_done_exec"}, DW'(done), DW'(0));
      if (noise) begin
         instr_valid = 1'b1; instr_rd = AW'(rd ^ 1); instr_rs2 = '0; instr_rs3 = '0; instr_op = 3'(op ^ 1);
      end
      ld_en = le_en; ld_addr = AW'(le_a); ld_data = le_d;
      tick();
      instr_valid = 1'b0; ld_en = 1'b0;
      sum = a + b;
      if (le_en && le_a != 0) mrf[le_a] = le_d;
      if (rd != 0) mrf[rd] = sum;
      chk({tag, "_done"}, DW'(done), DW'(1));
      chk({tag, "_result"}, result, sum);
      chk({tag, "_ready_done"}, DW'(instr_ready), DW'(1));
      chk({tag, "_aop_hold"}, DW'(aop), DW'(op));
   endtask

   initial begin
      logic [DW-1:0] hold_r2;
      model_reset();

      // 1. reset
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_ready", DW'(instr_ready), DW'(1));
      chk("rst_done", DW'(done), DW'(0));
      chk("rst_r2", r2, '0);
      chk("rst_r3", r3, '0);
      chk("rst_result", result, '0);
      chk_rf("rst");

      // 2. basic issue
      preload(1, 32'd5);
      preload(2, 32'd7);
      issue("basic", 7, 3, 1, 2, 0, 0, '0, 0, 0, '0, 0);
      chk("basic_sum", result, 32'd12);
      chk_rf("basic");

      // 3. back-to-back dependency with ignored valid in EXEC
      issue("dep", 2, 4, 3, 3, 0, 0, '0, 0, 0, '0, 1);
      chk("dep_sum", result, 32'd24);
      hold_r2 = r2;
      tick();
      chk("dep_done_low", DW'(done), DW'(0));
      chk("dep_r2_hold", r2, hold_r2);
      chk_rf("dep");

      // 4. wrap, then write to R0
      preload(1, 32'hFFFF_FFFF);
      preload(2, 32'd1);
      issue("wrap", 1, 5, 1, 2, 0, 0, '0, 0, 0, '0, 0);
      chk("wrap_sum", result, 32'd0);
      tick();
      issue("r0", 3, 0, 4, 4, 0, 0, '0, 0, 0, '0, 0);
      chk("r0_sum", result, 32'd48);
      chk_rf("r0");
      tick();

      // 5. same-cycle collisions
      issue("byp", 4, 6, 3, 4, 1, 3, 32'h1000_0000, 0, 0, '0, 0);
      chk("byp_r2", r2, 32'h1000_0000);
      tick();
      issue("wbwin", 5, 7, 1, 1, 0, 0, '0, 1, 7, 32'hDEAD_BEEF, 0);
      chk_rf("coll");
      tick();

      // 6. reset during EXEC
      preload(6, 32'h55);
      instr_valid = 1'b1; instr_rd = 3'd6; instr_rs2 = 3'd6; instr_rs3 = 3'd6;
      tick();
      instr_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_reset();
      chk("abort_done", DW'(done), DW'(0));
      chk("abort_ready", DW'(instr_ready), DW'(1));
      tick();
      chk("abort_done2", DW'(done), DW'(0));
      chk_rf("abort");

      // Randomized traffic
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            preload(int'($urandom_range(0, 7)), $urandom);
         end else begin
            issue($sformatf("rnd%0d", k), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                  bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) begin
               tick();
               chk($sformatf("rnd%0d_done_low", k), DW'(done), DW'(0));
            end
         end
      end
      chk_rf("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
